// File: rtl/unidade_multdiv_seq.sv
// Iterative unsigned multiply/divide unit for the EX stage: shift-add multiplication
// and restoring division, one bit per clock, producing a 2*LARGURA result on Hi/Lo.
module unidade_multdiv_seq #(
    parameter int         LARGURA = 32,
    parameter logic [2:0] OP_MULT = 3'b101,
    parameter logic [2:0] OP_DIV  = 3'b110
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic [2:0]         opCode,
    input  logic [LARGURA-1:0] operador1,
    input  logic [LARGURA-1:0] operador2,
    output logic               ocupado,
    output logic               pronto,
    output logic [LARGURA-1:0] resultadoHi,
    output logic [LARGURA-1:0] resultadoLo,
    output logic               divZero
);

    localparam int CW = $clog2(LARGURA + 1);

    typedef enum logic [1:0] {OCIOSO, MULT, DIV, FIM} estado_t;

    estado_t              estado;
    logic [CW-1:0]        contador;
    logic [2*LARGURA-1:0] acc;
    logic [LARGURA:0]     resto;
    logic [LARGURA-1:0]   op2;

    logic [LARGURA:0]     soma;
    logic [2*LARGURA-1:0] acc_mult;
    logic [LARGURA:0]     deslocado;
    logic [LARGURA:0]     diferenca;
    logic [LARGURA:0]     resto_div;
    logic [LARGURA-1:0]   quoc_div;
    logic                 cabe;
    logic                 aceita;
    logic                 ultima;

    // Multiply: acc = {partial product, remaining multiplier bits}; op2 holds the multiplicand.
    // Divide: acc[LARGURA-1:0] shifts dividend bits out MSB first and quotient bits in.
    always_comb begin
        soma      = {1'b0, acc[2*LARGURA-1:LARGURA]} + (acc[0] ? {1'b0, op2} : '0);
        acc_mult  = {soma, acc[LARGURA-1:1]};
        deslocado = {resto[LARGURA-1:0], acc[LARGURA-1]};
        // resto[LARGURA] is the bit shifted out of deslocado; if set, the divisor always fits
        cabe      = resto[LARGURA] || (deslocado >= {1'b0, op2});
        diferenca = deslocado - {1'b0, op2};
        resto_div = cabe ? diferenca : deslocado;
        quoc_div  = {acc[LARGURA-2:0], cabe};
        aceita    = iniciar && (opCode == OP_MULT || opCode == OP_DIV);
        ultima    = (contador == CW'(1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado      <= OCIOSO;
            contador    <= '0;
            acc         <= '0;
            resto       <= '0;
            op2         <= '0;
            ocupado     <= 1'b0;
            pronto      <= 1'b0;
            divZero     <= 1'b0;
            resultadoHi <= '0;
            resultadoLo <= '0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (aceita) begin
                        ocupado  <= 1'b1;
                        divZero  <= 1'b0;
                        contador <= CW'(LARGURA);
                        resto    <= '0;
                        if (opCode == OP_MULT) begin
                            acc    <= {{LARGURA{1'b0}}, operador2};
                            op2    <= operador1;
                            estado <= MULT;
                        end else begin
                            acc <= {{LARGURA{1'b0}}, operador1};
                            op2 <= operador2;
                            if (operador2 == '0) begin
                                resultadoLo <= '1;
                                resultadoHi <= operador1;
                                divZero     <= 1'b1;
                                pronto      <= 1'b1;
                                estado      <= FIM;
                            end else begin
                                estado <= DIV;
                            end
                        end
                    end
                end
                MULT: begin
                    acc      <= acc_mult;
                    contador <= contador - CW'(1);
                    if (ultima) begin
                        resultadoHi <= acc_mult[2*LARGURA-1:LARGURA];
                        resultadoLo <= acc_mult[LARGURA-1:0];
                        pronto      <= 1'b1;
                        estado      <= FIM;
                    end
                end
                DIV: begin
                    acc      <= {acc[2*LARGURA-1:LARGURA], quoc_div};
                    resto    <= resto_div;
                    contador <= contador - CW'(1);
                    if (ultima) begin
                        resultadoHi <= resto_div[LARGURA-1:0];
                        resultadoLo <= quoc_div;
                        pronto      <= 1'b1;
                        estado      <= FIM;
                    end
                end
                FIM: begin
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_multdiv_seq.sv
// Directed bench for unidade_multdiv_seq: multiply, divide, divide-by-zero, ignored starts,
// operand changes while busy and asynchronous reset mid-operation.
module tb_unidade_multdiv_seq;

    localparam logic [2:0] OP_MULT = 3'b101;
    localparam logic [2:0] OP_DIV  = 3'b110;

    logic        clock = 1'b0;
    logic        reset;
    logic        iniciar;
    logic [2:0]  opCode;
    logic [31:0] operador1;
    logic [31:0] operador2;
    logic        ocupado;
    logic        pronto;
    logic [31:0] resultadoHi;
    logic [31:0] resultadoLo;
    logic        divZero;

    int checks = 0;
    int passed = 0;
    int lat;

    unidade_multdiv_seq #(.LARGURA(32), .OP_MULT(OP_MULT), .OP_DIV(OP_DIV)) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .opCode      (opCode),
        .operador1   (operador1),
        .operador2   (operador2),
        .ocupado     (ocupado),
        .pronto      (pronto),
        .resultadoHi (resultadoHi),
        .resultadoLo (resultadoLo),
        .divZero     (divZero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a start request for one edge; returns at E0+1.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        opCode    = op;
        operador1 = a;
        operador2 = b;
        iniciar   = 1'b1;
        tick();
        iniciar   = 1'b0;
    endtask

    // Number of edges after E0 until pronto is seen, bounded.
    task automatic wait_pronto(output int n);
        n = 0;
        while (pronto !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz);
        int n;
        start_op(op, a, b);
        chk({tag, "_ocupado"}, 64'(ocupado), 64'(1'b1));
        wait_pronto(n);
        chk({tag, "_latencia"}, 64'(n), 64'(exp_lat));
        chk({tag, "_hi"}, 64'(resultadoHi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(resultadoLo), 64'(exp_lo));
        chk({tag, "_divzero"}, 64'(divZero), 64'(exp_dz));
        tick();
        chk({tag, "_pulso"}, 64'(pronto), 64'(1'b0));
        chk({tag, "_livre"}, 64'(ocupado), 64'(1'b0));
    endtask

    initial begin
        reset     = 1'b1;
        iniciar   = 1'b0;
        opCode    = 3'b000;
        operador1 = '0;
        operador2 = '0;
        repeat (2) tick();
        chk("rst_ocupado", 64'(ocupado), 64'(1'b0));
        chk("rst_pronto", 64'(pronto), 64'(1'b0));
        chk("rst_hi", 64'(resultadoHi), 64'd0);
        chk("rst_lo", 64'(resultadoLo), 64'd0);
        chk("rst_divzero", 64'(divZero), 64'(1'b0));
        reset = 1'b0;
        tick();

        run_op("mul_7x6", OP_MULT, 32'd7, 32'd6, 32, 32'd0, 32'd42, 1'b0);
        run_op("mul_max", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("div_100_7", OP_DIV, 32'd100, 32'd7, 32, 32'd2, 32'd14, 1'b0);
        run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 0, 32'd5, 32'hFFFF_FFFF, 1'b1);

        // A non mult/div opCode must not start the unit nor disturb held results.
        start_op(3'b000, 32'd11, 32'd22);
        chk("add_ocupado", 64'(ocupado), 64'(1'b0));
        for (int i = 0; i < 4; i++) begin
            chk("add_pronto", 64'(pronto), 64'(1'b0));
            tick();
        end
        chk("add_hi", 64'(resultadoHi), 64'd5);
        chk("add_lo", 64'(resultadoLo), 64'hFFFF_FFFF);
        chk("add_divzero", 64'(divZero), 64'(1'b1));

        run_op("mul_0x5", OP_MULT, 32'd0, 32'd5, 32, 32'd0, 32'd0, 1'b0);
        run_op("div_0_9", OP_DIV, 32'd0, 32'd9, 32, 32'd0, 32'd0, 1'b0);
        run_op("div_1000_33", OP_DIV, 32'd1000, 32'd33, 32, 32'd10, 32'd30, 1'b0);

        // Start 7*6, then a second request with new operands at cycle 10, and one more during FIM.
        start_op(OP_MULT, 32'd7, 32'd6);
        lat = 0;
        repeat (9) begin
            tick();
            lat++;
        end
        start_op(OP_MULT, 32'd3, 32'd3);
        lat++;
        chk("busy_ocupado", 64'(ocupado), 64'(1'b1));
        while (pronto !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        chk("busy_latencia", 64'(lat), 64'd32);
        chk("busy_lo", 64'(resultadoLo), 64'd42);
        chk("busy_hi", 64'(resultadoHi), 64'd0);
        start_op(OP_MULT, 32'd3, 32'd3);
        chk("fim_ign_ocupado", 64'(ocupado), 64'(1'b0));
        chk("fim_ign_pronto", 64'(pronto), 64'(1'b0));
        repeat (3) tick();
        chk("fim_ign_idle", 64'(ocupado), 64'(1'b0));

        // Asynchronous reset in the middle of 100/7, between clock edges.
        start_op(OP_DIV, 32'd100, 32'd7);
        repeat (14) tick();
        chk("pre_rst_ocupado", 64'(ocupado), 64'(1'b1));
        #2;
        reset = 1'b1;
        #1;
        chk("arst_ocupado", 64'(ocupado), 64'(1'b0));
        chk("arst_pronto", 64'(pronto), 64'(1'b0));
        chk("arst_hi", 64'(resultadoHi), 64'd0);
        chk("arst_lo", 64'(resultadoLo), 64'd0);
        chk("arst_divzero", 64'(divZero), 64'(1'b0));
        tick();
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (pronto !== 1'b0 || ocupado !== 1'b0) begin
                chk("arst_descartado", {pronto, ocupado}, 64'd0);
                break;
            end
            tick();
        end
        chk("arst_quieto", {pronto, ocupado}, 64'd0);

        run_op("div_9_2", OP_DIV, 32'd9, 32'd2, 32, 32'd1, 32'd4, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
